debug_autobaud: RTL and testbench

Automatic baud-rate detector for the debug UART. It watches the debug RX line for a host-sent sync character 0x55 ('U') and measures its edge-to-edge timing. From that measurement it computes the 7-bit preload for the debug baud rate generator. It drives that generator's `baud_set`/`baud_div` load interface, which makes it the initiator on the generator's preload-load path. A host can therefore connect at any supported rate without a CPU write.

---
 rtl/debug_autobaud.sv | 186 ++++++++++++++++++
 tb/tb_debug_autobaud.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_autobaud.sv
// Debug UART auto-baud detector: times a host 0x55 sync character on rx and
// loads the matching 7-bit preload into the debug baud generator.
module debug_autobaud #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned IDLE_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic       baud_set,
  output logic [6:0] baud_div,
  output logic       locked,
  output logic       busy,
  output logic       err
);

  localparam int unsigned IDLE_W = $clog2(IDLE_CYC + 1);
  localparam int unsigned EXT_W  = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_START, S_MEASURE, S_STOP, S_CALC
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d, sync2_q, sync2_d, rx_q, rx_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]   tot_q, tot_d, int_q, int_d, d1_q, d1_d;
  logic [EXT_W-1:0]   n_q, n_d;
  logic [3:0]         edge_idx_q, edge_idx_d;
  logic               baud_set_q, baud_set_d, locked_q, locked_d;
  logic               busy_q, busy_d, err_q, err_d;
  logic [6:0]         baud_div_q, baud_div_d;

  logic               edge_c, fall_c, tol_bad_c, q_bad_c, abort_c;
  logic [EXT_W-1:0]   d_cur_c, d1_ext_c, diff_c, q_c;

  // Interval measured at the current edge, and its deviation from the reference.
  always_comb begin
    edge_c    = sync2_q ^ rx_q;
    fall_c    = rx_q & ~sync2_q;
    d_cur_c   = EXT_W'(int_q) + EXT_W'(1);
    d1_ext_c  = EXT_W'(d1_q);
    diff_c    = (d_cur_c >= d1_ext_c) ? (d_cur_c - d1_ext_c) : (d1_ext_c - d_cur_c);
    tol_bad_c = diff_c > EXT_W'(d1_q >> 2);
    q_c       = (n_q + EXT_W'(128)) >> 8;
    q_bad_c   = (q_c == '0) || (q_c > EXT_W'(128));
  end

  always_comb begin
    state_d    = state_q;
    sync1_d    = rx;
    sync2_d    = sync1_q;
    rx_d       = sync2_q;
    idle_cnt_d = idle_cnt_q;
    tot_d      = tot_q;
    int_d      = int_q;
    d1_d       = d1_q;
    n_d        = n_q;
    edge_idx_d = edge_idx_q;
    baud_div_d = baud_div_q;
    locked_d   = locked_q;
    baud_set_d = 1'b0;
    err_d      = 1'b0;
    abort_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        idle_cnt_d = '0;
        if (en) state_d = S_ARM;
      end
      S_ARM: begin
        if (!sync2_q) idle_cnt_d = '0;
        else if (idle_cnt_q == IDLE_W'(IDLE_CYC - 1)) state_d = S_WAIT_START;
        else idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
      S_WAIT_START: begin
        if (fall_c) begin
          state_d    = S_MEASURE;
          tot_d      = '0;
          int_d      = '0;
          edge_idx_d = 4'd1;
        end
      end
      S_MEASURE: begin
        tot_d = tot_q + CNT_W'(1);
        int_d = int_q + CNT_W'(1);
        if (tot_q == CNT_MAX) begin
          abort_c = 1'b1;
        end else if (edge_c) begin
          int_d = '0;
          if (edge_idx_q == 4'd1) d1_d = CNT_W'(d_cur_c);
          else if (tol_bad_c) abort_c = 1'b1;
          if (!abort_c) begin
            edge_idx_d = edge_idx_q + 4'd1;
            if (edge_idx_q == 4'd8) begin
              n_d     = EXT_W'(tot_q) + EXT_W'(1);
              state_d = S_STOP;
            end
          end
        end
      end
      S_STOP: begin
        int_d = int_q + CNT_W'(1);
        if (edge_c) begin
          if (tol_bad_c) abort_c = 1'b1;
          else state_d = S_CALC;
        end else if (d_cur_c > (d1_ext_c << 1)) begin
          abort_c = 1'b1;
        end
      end
      S_CALC: begin
        if (q_bad_c) begin
          abort_c = 1'b1;
        end else begin
          baud_div_d = 7'(q_c - EXT_W'(1));
          baud_set_d = 1'b1;
          locked_d   = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_c) begin
      err_d      = 1'b1;
      idle_cnt_d = '0;
      state_d    = en ? S_ARM : S_IDLE;
    end

    // Disable overrides any completion or abort in the same cycle.
    if (!en) begin
      state_d    = S_IDLE;
      locked_d   = 1'b0;
      baud_set_d = 1'b0;
      err_d      = 1'b0;
      baud_div_d = baud_div_q;
    end

    busy_d = (state_d == S_MEASURE) || (state_d == S_STOP) || (state_d == S_CALC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_q       <= 1'b1;
      idle_cnt_q <= '0;
      tot_q      <= '0;
      int_q      <= '0;
      d1_q       <= '0;
      n_q        <= '0;
      edge_idx_q <= '0;
      baud_set_q <= 1'b0;
      baud_div_q <= 7'h0C;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rx_q       <= rx_d;
      idle_cnt_q <= idle_cnt_d;
      tot_q      <= tot_d;
      int_q      <= int_d;
      d1_q       <= d1_d;
      n_q        <= n_d;
      edge_idx_q <= edge_idx_d;
      baud_set_q <= baud_set_d;
      baud_div_q <= baud_div_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign baud_set = baud_set_q;
  assign baud_div = baud_div_q;
  assign locked   = locked_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_debug_autobaud.sv
// Bench for debug_autobaud: sends 0x55 frames with chosen bit lengths and
// scores every baud_set/err strobe against an arithmetic model of the detector.
module tb_debug_autobaud;

  logic       clk = 1'b0;
  logic       rst, en, rx;
  logic       baud_set, locked, busy, err;
  logic [6:0] baud_div;

  debug_autobaud #(.CNT_W(16), .IDLE_CYC(1024)) dut (
    .clk(clk), .rst(rst), .en(en), .rx(rx),
    .baud_set(baud_set), .baud_div(baud_div),
    .locked(locked), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [6:0] div;
    bit         lk;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         bl[10];
  bit         m_locked = 1'b0;
  logic [6:0] m_div    = 7'h0C;
  bit         busy_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Outcome of a frame from its bit lengths: tolerance on each interval, then range of Q.
  task automatic model_frame();
    int   d1, n, q;
    bit   ok;
    exp_t e;
    d1 = bl[0];
    ok = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      int d, dev;
      d   = bl[k-1];
      dev = (d > d1) ? d - d1 : d1 - d;
      if (dev > d1 / 4) ok = 1'b0;
    end
    n = 0;
    for (int k = 0; k < 8; k++) n += bl[k];
    q = (n + 128) / 256;
    if (ok && q >= 1 && q <= 128) begin
      m_locked = 1'b1;
      m_div    = 7'(q - 1);
      e.is_err = 1'b0;
    end else begin
      e.is_err = 1'b1;
    end
    e.div = m_div;
    e.lk  = m_locked;
    exp_q.push_back(e);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 10; i++) bl[i] = v;
  endtask

  task automatic send_frame(input int idle, input bit predict);
    logic [7:0] sc;
    sc = 8'h55;
    rx = 1'b1;
    repeat (idle) @(negedge clk);
    if (predict) model_frame();
    for (int b = 0; b < 10; b++) begin
      if (b == 0) rx = 1'b0;
      else if (b == 9) rx = 1'b1;
      else rx = sc[b-1];
      repeat (bl[b]) @(negedge clk);
    end
  endtask

  task automatic drain_check(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_pending"}, 32'(exp_q.size()), 0);
    exp_q.delete();
    check({tag, "_locked"}, 32'(locked), 32'(m_locked));
    check({tag, "_div"}, 32'(baud_div), 32'(m_div));
  endtask

  task automatic hold(input logic lvl, input int n);
    rx = lvl;
    repeat (n) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest predicted outcome.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (baud_set || err)) begin
      check("strobe_overlap", 32'(baud_set & err), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind_err", 32'(err), 32'(e.is_err));
        check("strobe_div", 32'(baud_div), 32'(e.div));
        check("strobe_locked", 32'(locked), 32'(e.lk));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_baud_set", 32'(baud_set), 0);
    check("rst_baud_div", 32'(baud_div), 12);
    check("rst_locked", 32'(locked), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;
    en  = 1'b1;

    set_all(416);
    send_frame(2000, 1'b1);
    drain_check("nominal");
    check("nominal_known_div", 32'(baud_div), 12);

    set_all(32);
    send_frame(1100, 1'b1);
    drain_check("fastest");
    check("fastest_known_div", 32'(baud_div), 0);

    set_all(8);
    send_frame(1100, 1'b1);
    drain_check("q_zero");

    set_all(4128);
    send_frame(1100, 1'b1);
    drain_check("out_of_range");
    check("oor_known_locked", 32'(locked), 1);

    set_all(416);
    bl[3] = 560;
    send_frame(1100, 1'b1);
    drain_check("jitter");

    set_all(200);
    send_frame(1100, 1'b1);
    drain_check("relock");
    check("relock_known_div", 32'(baud_div), 5);

    busy_seen = 1'b0;
    hold(1'b0, 50);
    hold(1'b1, 500);
    hold(1'b0, 300);
    hold(1'b1, 200);
    check("short_idle_busy", 32'(busy_seen), 0);
    drain_check("short_idle");

    set_all(64);
    fork
      send_frame(1100, 1'b0);
      begin
        repeat (1100 + 8 * 64 + 32) @(negedge clk);
        check("stop_busy", 32'(busy), 1);
        en = 1'b0;
        @(negedge clk);
        check("en_drop_locked", 32'(locked), 0);
        check("en_drop_busy", 32'(busy), 0);
      end
    join
    m_locked = 1'b0;
    en = 1'b1;
    drain_check("en_drop");

    for (int i = 0; i < 4; i++) begin
      int base, m;
      base = int'($urandom_range(20, 200));
      m    = ($urandom_range(0, 1) != 0) ? base * 3 / 10 : 0;
      for (int j = 0; j < 9; j++) bl[j] = base + int'($urandom_range(0, 2 * m)) - m;
      bl[9] = base;
      send_frame(1100, 1'b1);
      drain_check("random");
    end

    set_all(100);
    send_frame(1100, 1'b1);
    drain_check("pre_reset");
    check("pre_reset_known_div", 32'(baud_div), 2);

    set_all(64);
    fork
      send_frame(1100, 1'b0);
      begin
        repeat (1100 + 5 * 64 + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_baud_set", 32'(baud_set), 0);
        check("midrst_baud_div", 32'(baud_div), 12);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_err", 32'(err), 0);
        rst = 1'b0;
      end
    join
    m_locked = 1'b0;
    m_div    = 7'h0C;
    drain_check("mid_reset");

    set_all(int'($urandom_range(40, 200)));
    send_frame(1100, 1'b1);
    drain_check("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
